// File: rtl/rift2_mbx_pkg.sv
// Shared definitions for the rift2 Wishbone mailbox: register map, bit positions,
// default FIFO depth and the STATUS word packer.
package rift2_mbx_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int CNT_W         = 5;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_RXDATA = 2'd1,
        REG_STATUS = 2'd2,
        REG_CTRL   = 2'd3
    } mbx_reg_e;

    localparam int ST_H2C_FULL  = 0;
    localparam int ST_H2C_EMPTY = 1;
    localparam int ST_C2H_FULL  = 2;
    localparam int ST_C2H_EMPTY = 3;
    localparam int ST_OVF       = 4;
    localparam int ST_UDF       = 5;
    localparam int ST_H2C_CNT   = 8;
    localparam int ST_C2H_CNT   = 16;

    localparam int CTRL_IRQ_EN    = 0;
    localparam int CTRL_FLUSH     = 1;
    localparam int CTRL_CLR_STICKY = 2;

    function automatic logic [31:0] pack_status(
        input logic             h2c_full,
        input logic             h2c_empty,
        input logic             c2h_full,
        input logic             c2h_empty,
        input logic             ovf,
        input logic             udf,
        input logic [CNT_W-1:0] h2c_cnt,
        input logic [CNT_W-1:0] c2h_cnt
    );
        logic [31:0] s;
        s = 32'd0;
        s[ST_H2C_FULL]            = h2c_full;
        s[ST_H2C_EMPTY]           = h2c_empty;
        s[ST_C2H_FULL]            = c2h_full;
        s[ST_C2H_EMPTY]           = c2h_empty;
        s[ST_OVF]                 = ovf;
        s[ST_UDF]                 = udf;
        s[ST_H2C_CNT +: CNT_W]    = h2c_cnt;
        s[ST_C2H_CNT +: CNT_W]    = c2h_cnt;
        return s;
    endfunction

endpackage

// File: rtl/rift2_mbx_fifo.sv
// Synchronous FIFO with occupancy count and a flush that wins over push/pop.
// Pushes into a full FIFO and pops from an empty one are ignored.
module rift2_mbx_fifo
    import rift2_mbx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    // Empty FIFO presents zero rather than stale storage
    assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) mem_r[wr_ptr_r] <= push_data;
    end

endmodule

// File: rtl/rift2_wb_mailbox.sv
// Wishbone classic slave exposing a host-to-core and a core-to-host mailbox FIFO,
// with sticky overflow/underflow flags and a level interrupt on pending C2H data.
module rift2_wb_mailbox
    import rift2_mbx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = DEFAULT_DEPTH
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        h2c_valid_o,
    output logic [31:0] h2c_data_o,
    input  logic        h2c_ready_i,
    input  logic        c2h_valid_i,
    input  logic [31:0] c2h_data_i,
    output logic        c2h_ready_o,
    output logic        irq_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          ack_r;
    logic [31:0]   dat_r;
    logic          irq_en_r;
    logic          ovf_r;
    logic          udf_r;
    logic          irq_r;
    logic          blocked_r;

    logic          req_s;
    logic          hit_s;
    logic          commit_s;
    logic          full_wr_s;
    mbx_reg_e      reg_s;
    logic          tx_wr_s;
    logic          rx_rd_s;
    logic          ctrl_wr_s;
    logic          flush_s;
    logic          clr_s;
    logic          ovf_evt_s;
    logic          udf_evt_s;
    logic          h2c_pop_s;
    logic          c2h_push_s;
    logic [31:0]   rdata_s;

    logic [31:0]   c2h_head_s;
    logic [CW-1:0] h2c_count_s;
    logic [CW-1:0] c2h_count_s;
    logic          h2c_full_s;
    logic          h2c_empty_s;
    logic          c2h_full_s;
    logic          c2h_empty_s;

    // A request still asserted across reset release is the abandoned one;
    // decoding resumes only once the bus has gone idle.
    assign req_s     = wbs_cyc_i & wbs_stb_i;
    assign hit_s     = req_s & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~blocked_r;
    assign commit_s  = hit_s & ~ack_r;
    assign reg_s     = mbx_reg_e'(wbs_adr_i[3:2]);
    assign full_wr_s = wbs_we_i & (wbs_sel_i == 4'hF);

    assign tx_wr_s   = commit_s & full_wr_s & (reg_s == REG_TXDATA);
    assign rx_rd_s   = commit_s & ~wbs_we_i & (reg_s == REG_RXDATA);
    assign ctrl_wr_s = commit_s & full_wr_s & (reg_s == REG_CTRL);
    assign flush_s   = ctrl_wr_s & wbs_dat_i[CTRL_FLUSH];
    assign clr_s     = ctrl_wr_s & wbs_dat_i[CTRL_CLR_STICKY];
    assign ovf_evt_s = tx_wr_s & h2c_full_s;
    assign udf_evt_s = rx_rd_s & c2h_empty_s;

    assign h2c_valid_o = ~h2c_empty_s;
    assign h2c_pop_s   = ~h2c_empty_s & h2c_ready_i;
    assign c2h_ready_o = ~c2h_full_s;
    assign c2h_push_s  = c2h_valid_i & ~c2h_full_s;

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;
    assign irq_o     = irq_r;

    rift2_mbx_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_h2c (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .flush     (flush_s),
        .push      (tx_wr_s),
        .push_data (wbs_dat_i),
        .pop       (h2c_pop_s),
        .head      (h2c_data_o),
        .count     (h2c_count_s),
        .full      (h2c_full_s),
        .empty     (h2c_empty_s)
    );

    rift2_mbx_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_c2h (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .flush     (flush_s),
        .push      (c2h_push_s),
        .push_data (c2h_data_i),
        .pop       (rx_rd_s),
        .head      (c2h_head_s),
        .count     (c2h_count_s),
        .full      (c2h_full_s),
        .empty     (c2h_empty_s)
    );

    // Read-data multiplexer
    always_comb begin
        rdata_s = 32'd0;
        case (reg_s)
            REG_TXDATA: rdata_s = 32'd0;
            REG_RXDATA: rdata_s = c2h_head_s;
            REG_STATUS: rdata_s = pack_status(h2c_full_s, h2c_empty_s, c2h_full_s, c2h_empty_s,
                                              ovf_r, udf_r, CNT_W'(h2c_count_s), CNT_W'(c2h_count_s));
            REG_CTRL:   rdata_s = {31'd0, irq_en_r};
            default:    rdata_s = 32'd0;
        endcase
    end

    // Bus response, control and sticky-flag registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_r     <= 1'b0;
            dat_r     <= 32'd0;
            irq_en_r  <= 1'b0;
            ovf_r     <= 1'b0;
            udf_r     <= 1'b0;
            irq_r     <= 1'b0;
            blocked_r <= 1'b1;
        end else begin
            ack_r     <= commit_s;
            dat_r     <= (commit_s && !wbs_we_i) ? rdata_s : 32'd0;
            blocked_r <= blocked_r & req_s;
            if (ctrl_wr_s) irq_en_r <= wbs_dat_i[CTRL_IRQ_EN];
            ovf_r     <= ovf_evt_s | (ovf_r & ~clr_s);
            udf_r     <= udf_evt_s | (udf_r & ~clr_s);
            irq_r     <= irq_en_r & ~c2h_empty_s;
        end
    end

endmodule

// File: doc/rift2_wb_mailbox.md
RIFT2_WB_MAILBOX -- requirements
Module: rift2_wb_mailbox

Interface
REQ-001 SHALL have parameters: BASE_ADDR 32'h3000_0000, Wishbone base (match wbs_adr_i[31:4]); DEPTH 4, entries per FIFO (power of two, 2..16).
REQ-002 SHALL have ports: wb_clk_i in 1, sole clock; wb_rst_n_i in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: wbs_cyc_i, wbs_stb_i, wbs_we_i in 1; wbs_sel_i in 4; wbs_adr_i, wbs_dat_i in 32; Wishbone classic slave inputs.
REQ-004 SHALL have ports: wbs_ack_o out 1; wbs_dat_o out 32; Wishbone slave outputs.
REQ-005 SHALL have ports: h2c_valid_o out 1, h2c_data_o out 32, h2c_ready_i in 1; host-to-core stream to the rift2 core.
REQ-006 SHALL have ports: c2h_valid_i in 1, c2h_data_i in 32, c2h_ready_o out 1; core-to-host stream.
REQ-007 SHALL have port irq_o out 1; level interrupt, wired to user_irq[0].

Function
REQ-008 SHALL decode only when cyc&stb and wbs_adr_i[31:4]==BASE_ADDR[31:4]; register select is wbs_adr_i[3:2].
REQ-009 SHALL register map: 0x0 TXDATA (W push H2C; R 0), 0x4 RXDATA (R pop C2H; W ignored), 0x8 STATUS (RO), 0xC CTRL (RW).
REQ-010 SHALL use STATUS: [0] h2c_full, [1] h2c_empty, [2] c2h_full, [3] c2h_empty, [4] ovf sticky, [5] udf sticky, [12:8] h2c count, [20:16] c2h count, others 0.
REQ-011 SHALL use CTRL: [0] irq_en (RW), [1] flush (W1, self-clearing, reads 0), [2] clr_sticky (W1, self-clearing, reads 0).
REQ-012 SHALL assert wbs_ack_o for exactly one cycle, registered, the cycle after a decoded request; ack never on consecutive cycles; non-decoded requests never acked.
REQ-013 SHALL perform the register side effect (push/pop/CTRL write) once, in the cycle ack is asserted, and present read data with ack.
REQ-014 SHALL apply writes only when all wbs_sel_i bits are 1; partial writes are acked and ignored.
REQ-015 SHALL drop a TXDATA write when H2C is full and set ovf; drop-free otherwise.
REQ-016 SHALL return 0 for an RXDATA read when C2H is empty and set udf; no pop occurs.
REQ-017 SHALL expose FIFO head combinationally: h2c_valid_o = !h2c_empty, h2c_data_o = head; pop on h2c_valid_o&h2c_ready_i.
REQ-018 SHALL drive c2h_ready_o = !c2h_full; push on c2h_valid_i&c2h_ready_o; no same-cycle bypass when full.
REQ-019 SHALL allow simultaneous push and pop in one FIFO per cycle, count unchanged; pointers wrap modulo DEPTH.
REQ-020 SHALL on flush empty both FIFOs in the ack cycle, overriding any same-cycle stream push/pop.
REQ-021 SHALL drive irq_o = irq_en & !c2h_empty, registered (one cycle after condition).
REQ-022 SHALL give clr_sticky priority below a same-cycle new ovf/udf event (event wins).

Reset
REQ-023 SHALL on wb_rst_n_i low, asynchronously: FIFOs empty, pointers 0, ack 0, wbs_dat_o 0, irq_en 0, sticky 0, irq_o 0.
REQ-024 SHALL, if reset asserts mid-transaction, abandon it; no ack is issued after reset release for the old request.

Structure
REQ-025 SHALL place register offsets, STATUS/CTRL bit indices and default DEPTH in package rift2_mbx_pkg.
REQ-026 SHALL implement each direction by sub-module rift2_mbx_fifo (sync FIFO, width 32, DEPTH, count/full/empty/flush), instantiated twice.

Verification
REQ-027 SHALL test: write 0xDEADBEEF to TXDATA, h2c_ready_i=1 -> ack 1 cycle later, h2c_valid_o with 0xDEADBEEF next cycle, STATUS[1]=1 afterwards.
REQ-028 SHALL test: 5 TXDATA writes with h2c_ready_i=0, DEPTH=4 -> STATUS h2c count=4, ovf=1, h2c data order = first four values.
REQ-029 SHALL test: core pushes 0x11,0x22 with irq_en=1 -> irq_o rises; two RXDATA reads return 0x11,0x22; irq_o falls; third read returns 0, udf=1.
REQ-030 SHALL test: C2H full, simultaneous RXDATA pop and c2h_valid_i -> c2h_ready_o 0 that cycle, count 3 after, next push accepted.
REQ-031 SHALL test: CTRL write 0x2 with both FIFOs non-empty -> both empty next cycle, STATUS[1]=STATUS[3]=1, CTRL reads 0x0/0x1.
REQ-032 SHALL test: reset pulse during stb held high -> no ack, all outputs 0, STATUS reads 0x0000_000A after release.
